// File: rtl/clint_arb.sv
// clint_arb: round-robin two-port arbiter and one-shot access sequencer for the CLINT MMIO port.
// Each grant runs IDLE -> ACCESS (single-cycle strobe) -> RESP (single-cycle rvalid).
`default_nettype none

module clint_arb #(
  parameter logic [63:0] ADDR_MTIME    = 64'h200_BFF8,
  parameter logic [63:0] ADDR_MTIMECMP = 64'h200_4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_Req0_valid,
  input  logic        i_Req0_wen,
  input  logic [63:0] i_Req0_addr,
  input  logic [63:0] i_Req0_wr_data,
  output logic        o_Req0_ready,
  output logic        o_Req0_rvalid,
  output logic [63:0] o_Req0_rd_data,
  output logic        o_Req0_err,
  input  logic        i_Req1_valid,
  input  logic        i_Req1_wen,
  input  logic [63:0] i_Req1_addr,
  input  logic [63:0] i_Req1_wr_data,
  output logic        o_Req1_ready,
  output logic        o_Req1_rvalid,
  output logic [63:0] o_Req1_rd_data,
  output logic        o_Req1_err,
  output logic [63:0] o_Clint_addr,
  output logic [63:0] o_Clint_wr_data,
  output logic        o_Clint_wen,
  output logic        o_Clint_ren,
  input  logic [63:0] i_Clint_rd_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        last_grant;
  logic        lat_id;
  logic        lat_wen;
  logic [63:0] lat_addr;
  logic [63:0] lat_wr_data;
  logic        any_valid;
  logic        win_id;
  logic        take;
  logic        in_access;
  logic        addr_hit;
  logic [63:0] resp_data;

  // Port 1 wins only when alone or when port 0 held the previous grant.
  assign any_valid = i_Req0_valid | i_Req1_valid;
  assign win_id    = i_Req1_valid & (~i_Req0_valid | ~last_grant);
  assign take      = (state == IDLE) & any_valid;
  assign in_access = (state == ACCESS);
  assign addr_hit  = (lat_addr == ADDR_MTIME) | (lat_addr == ADDR_MTIMECMP);
  assign resp_data = lat_wen ? 64'd0 : i_Clint_rd_data;

  // Idle address/data are forced to zero so the CLINT read mux sees nothing.
  assign o_Clint_addr    = in_access ? lat_addr : 64'd0;
  assign o_Clint_wr_data = in_access ? lat_wr_data : 64'd0;
  assign o_Clint_wen     = in_access & addr_hit & lat_wen;
  assign o_Clint_ren     = in_access & addr_hit & ~lat_wen;

  always_comb begin
    state_nxt    = state;
    o_Req0_ready = 1'b0;
    o_Req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid && !rst) begin
          state_nxt    = ACCESS;
          o_Req0_ready = ~win_id;
          o_Req1_ready = win_id;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant     <= 1'b1;
      lat_id         <= 1'b0;
      lat_wen        <= 1'b0;
      lat_addr       <= 64'd0;
      lat_wr_data    <= 64'd0;
      o_Req0_rvalid  <= 1'b0;
      o_Req1_rvalid  <= 1'b0;
      o_Req0_rd_data <= 64'd0;
      o_Req1_rd_data <= 64'd0;
      o_Req0_err     <= 1'b0;
      o_Req1_err     <= 1'b0;
    end else begin
      o_Req0_rvalid <= 1'b0;
      o_Req1_rvalid <= 1'b0;
      if (take) begin
        last_grant  <= win_id;
        lat_id      <= win_id;
        lat_wen     <= win_id ? i_Req1_wen : i_Req0_wen;
        lat_addr    <= win_id ? i_Req1_addr : i_Req0_addr;
        lat_wr_data <= win_id ? i_Req1_wr_data : i_Req0_wr_data;
      end
      // Response registers load on the ACCESS->RESP edge; only the winner's copy moves.
      if (in_access) begin
        if (!lat_id) begin
          o_Req0_rvalid  <= 1'b1;
          o_Req0_rd_data <= resp_data;
          o_Req0_err     <= ~addr_hit;
        end else begin
          o_Req1_rvalid  <= 1'b1;
          o_Req1_rd_data <= resp_data;
          o_Req1_err     <= ~addr_hit;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clint_arb.sv
// tb_clint_arb: directed scenarios plus a randomized lockstep run against a timestamp-based reference model.
`default_nettype none

module tb_clint_arb;

  localparam logic [63:0] MTIME = 64'h200_BFF8;
  localparam logic [63:0] MTCMP = 64'h200_4000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v0 = 0, w0 = 0, v1 = 0, w1 = 0;
  logic [63:0] a0 = 0, d0 = 0, a1 = 0, d1 = 0;
  logic        r0, r1, rv0, rv1, e0, e1, cwen, cren;
  logic [63:0] rd0, rd1, caddr, cwd, crd;

  logic [63:0] mtime = 64'd0;
  logic [63:0] mtimecmp = 64'd0;
  logic        mt_load = 1'b0;
  logic [63:0] mt_load_val = 64'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clint_arb dut (
    .clk(clk), .rst(rst),
    .i_Req0_valid(v0), .i_Req0_wen(w0), .i_Req0_addr(a0), .i_Req0_wr_data(d0),
    .o_Req0_ready(r0), .o_Req0_rvalid(rv0), .o_Req0_rd_data(rd0), .o_Req0_err(e0),
    .i_Req1_valid(v1), .i_Req1_wen(w1), .i_Req1_addr(a1), .i_Req1_wr_data(d1),
    .o_Req1_ready(r1), .o_Req1_rvalid(rv1), .o_Req1_rd_data(rd1), .o_Req1_err(e1),
    .o_Clint_addr(caddr), .o_Clint_wr_data(cwd), .o_Clint_wen(cwen), .o_Clint_ren(cren),
    .i_Clint_rd_data(crd)
  );

  // Behavioural CLINT: free-running mtime, writable mtimecmp, combinational read.
  assign crd = (caddr == MTIME) ? mtime : (caddr == MTCMP) ? mtimecmp : 64'd0;
  always @(posedge clk) begin
    if (mt_load) mtime <= mt_load_val;
    else if (cwen && caddr == MTIME) mtime <= cwd;
    else mtime <= mtime + 64'd1;
    if (cwen && caddr == MTCMP) mtimecmp <= cwd;
  end

  task automatic drop_and_settle();
    @(negedge clk);
    v0 = 0; v1 = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    v0 = 0; v1 = 0; rst = 1;
    @(negedge clk); #1;
    checks++;
    if ({r0, r1, rv0, rv1, e0, e1, cwen, cren} !== 8'd0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000000", {r0, r1, rv0, rv1, e0, e1, cwen, cren});
    end
    checks++;
    if ({rd0, rd1, caddr, cwd} !== 256'd0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h exp 0", rd0, rd1, caddr, cwd);
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_single_read();
    mt_load = 1; mt_load_val = 64'd4;
    @(negedge clk);
    mt_load = 0; v0 = 1; w0 = 0; a0 = MTIME; d0 = 0; #1;
    checks++;
    if (r0 !== 1 || r1 !== 0 || cren !== 0) begin
      errors++; $display("FAIL read_T got r0=%b r1=%b ren=%b exp 1 0 0", r0, r1, cren);
    end
    @(negedge clk); v0 = 0; #1;
    checks++;
    if (cren !== 1 || cwen !== 0 || caddr !== MTIME || r0 !== 0) begin
      errors++; $display("FAIL read_T1 got ren=%b wen=%b addr=%h r0=%b exp 1 0 %h 0", cren, cwen, caddr, r0, MTIME);
    end
    @(negedge clk); #1;
    checks++;
    if (rv0 !== 1 || rd0 !== 64'd5 || e0 !== 0 || rv1 !== 0 || cren !== 0) begin
      errors++; $display("FAIL read_T2 got rv0=%b rd0=%0d err=%b rv1=%b ren=%b exp 1 5 0 0 0", rv0, rd0, e0, rv1, cren);
    end
    @(negedge clk); #1;
    checks++;
    if (rv0 !== 0 || rd0 !== 64'd5) begin
      errors++; $display("FAIL read_hold got rv0=%b rd0=%0d exp 0 5", rv0, rd0);
    end
    drop_and_settle();
  endtask

  task automatic test_write_cmp();
    @(negedge clk);
    v1 = 1; w1 = 1; a1 = MTCMP; d1 = 64'd100; #1;
    checks++;
    if (r1 !== 1 || r0 !== 0) begin
      errors++; $display("FAIL wcmp_ready got r1=%b r0=%b exp 1 0", r1, r0);
    end
    @(negedge clk); v1 = 0; #1;
    checks++;
    if (cwen !== 1 || cren !== 0 || cwd !== 64'd100 || caddr !== MTCMP) begin
      errors++; $display("FAIL wcmp_strobe got wen=%b ren=%b wd=%0d addr=%h exp 1 0 100 %h", cwen, cren, cwd, caddr, MTCMP);
    end
    @(negedge clk); #1;
    checks++;
    if (cwen !== 0 || rv1 !== 1 || rd1 !== 64'd0 || e1 !== 0 || rv0 !== 0) begin
      errors++; $display("FAIL wcmp_resp got wen=%b rv1=%b rd1=%0d err=%b rv0=%b exp 0 1 0 0 0", cwen, rv1, rd1, e1, rv0);
    end
    @(negedge clk);
    v1 = 1; w1 = 0; a1 = MTCMP; d1 = 0; #1;
    checks++;
    if (r1 !== 1) begin
      errors++; $display("FAIL rcmp_ready got %b exp 1", r1);
    end
    @(negedge clk); v1 = 0;
    @(negedge clk); #1;
    checks++;
    if (rv1 !== 1 || rd1 !== 64'd100) begin
      errors++; $display("FAIL rcmp_data got rv1=%b rd1=%0d exp 1 100", rv1, rd1);
    end
    drop_and_settle();
  endtask

  task automatic test_contention();
    test_reset();
    @(negedge clk);
    v0 = 1; w0 = 0; a0 = MTIME; v1 = 1; w1 = 0; a1 = MTCMP; #1;
    checks++;
    if (r0 !== 1 || r1 !== 0) begin
      errors++; $display("FAIL cont_first got r0=%b r1=%b exp 1 0", r0, r1);
    end
    @(negedge clk); v0 = 0; #1;
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (r0 !== 0 || r1 !== 0) begin
        errors++; $display("FAIL cont_wait%0d got r0=%b r1=%b exp 0 0", i, r0, r1);
      end
      @(negedge clk); #1;
    end
    checks++;
    if (r1 !== 1 || r0 !== 0) begin
      errors++; $display("FAIL cont_second got r0=%b r1=%b exp 0 1", r0, r1);
    end
    @(negedge clk); v0 = 1;
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (r0 !== 1 || r1 !== 0) begin
      errors++; $display("FAIL cont_third got r0=%b r1=%b exp 1 0", r0, r1);
    end
    drop_and_settle();
  endtask

  task automatic test_decode_err();
    @(negedge clk);
    v0 = 1; w0 = 1; a0 = 64'h200_0000; d0 = 64'd55;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (cwen !== 0 || cren !== 0) begin
        errors++; $display("FAIL derr_strobe%0d got wen=%b ren=%b exp 0 0", i, cwen, cren);
      end
      @(negedge clk); v0 = 0;
    end
    // back at the negedge of T+3, response was visible during T+2: recheck latched outputs
    checks++;
    if (e0 !== 1 || rd0 !== 64'd0) begin
      errors++; $display("FAIL derr_resp got err=%b rd0=%h exp 1 0", e0, rd0);
    end
    drop_and_settle();
  endtask

  task automatic test_mid_reset();
    bit seen;
    @(negedge clk);
    v0 = 1; w0 = 1; a0 = MTCMP; d0 = 64'd7; #1;
    checks++;
    if (r0 !== 1) begin
      errors++; $display("FAIL mrst_ready got %b exp 1", r0);
    end
    @(negedge clk); v0 = 0; #1;
    checks++;
    if (cwen !== 1) begin
      errors++; $display("FAIL mrst_access got wen=%b exp 1", cwen);
    end
    rst = 1; #1;
    checks++;
    if (cwen !== 0 || cren !== 0 || caddr !== 64'd0) begin
      errors++; $display("FAIL mrst_drop got wen=%b ren=%b addr=%h exp 0 0 0", cwen, cren, caddr);
    end
    @(negedge clk); rst = 0;
    seen = 0;
    repeat (4) begin
      #1; if (rv0 || rv1) seen = 1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL mrst_rvalid got %b exp 0", seen);
    end
    v0 = 1; w0 = 0; a0 = MTIME; v1 = 1; w1 = 0; a1 = MTIME; #1;
    checks++;
    if (r0 !== 1 || r1 !== 0) begin
      errors++; $display("FAIL mrst_cont got r0=%b r1=%b exp 1 0", r0, r1);
    end
    drop_and_settle();
  endtask

  task automatic test_back_to_back();
    int nready, nresp, last_c;
    logic [63:0] last_val;
    nready = 0; nresp = 0; last_c = 0; last_val = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin v1 = 1; w1 = 0; a1 = MTIME; d1 = 0; end
      if (nready == 10) v1 = 0;
      #1;
      if (r1) begin
        if (nready > 0) begin
          checks++;
          if (c - last_c !== 3) begin
            errors++; $display("FAIL b2b_spacing got %0d exp 3", c - last_c);
          end
        end
        last_c = c; nready++;
      end
      if (rv1) begin
        if (nresp > 0) begin
          checks++;
          if (rd1 - last_val !== 64'd3) begin
            errors++; $display("FAIL b2b_delta got %0d exp 3", rd1 - last_val);
          end
        end
        last_val = rd1; nresp++;
      end
    end
    checks++;
    if (nready !== 10 || nresp !== 10) begin
      errors++; $display("FAIL b2b_count got ready=%0d rvalid=%0d exp 10 10", nready, nresp);
    end
    drop_and_settle();
  endtask

  // Lockstep reference: each grant at cycle g implies strobe at g+1, response at g+2, next grant no earlier than g+3.
  task automatic test_random();
    int          grant_c, next_free;
    logic        m_last, win, hit;
    logic        t_id, t_wen;
    logic [63:0] t_addr, t_wd, ref_mtime, ref_cmp, exp_data;
    logic        exp_err, got0, got1;
    logic        e_r0, e_r1, e_wen, e_ren, e_rv0, e_rv1;
    logic [63:0] e_addr, e_wd;
    grant_c = -100; next_free = 0; m_last = 1;
    t_id = 0; t_wen = 0; t_addr = 0; t_wd = 0; exp_data = 0; exp_err = 0; hit = 0;
    got0 = 0; got1 = 0; ref_mtime = 0; ref_cmp = 0;
    test_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c == 0) begin ref_mtime = mtime; ref_cmp = mtimecmp; end
      if (v0 && got0) v0 = 0;
      else if (!v0 && $urandom_range(0, 99) < 40) begin
        int k; k = $urandom_range(0, 9);
        v0 = 1; w0 = $urandom_range(0, 1) == 1; d0 = {$urandom, $urandom};
        a0 = (k < 4) ? MTIME : (k < 8) ? MTCMP : 64'h200_0000 + 64'($urandom_range(0, 255) * 8);
      end
      if (v1 && got1) v1 = 0;
      else if (!v1 && $urandom_range(0, 99) < 40) begin
        int k; k = $urandom_range(0, 9);
        v1 = 1; w1 = $urandom_range(0, 1) == 1; d1 = {$urandom, $urandom};
        a1 = (k < 4) ? MTIME : (k < 8) ? MTCMP : 64'h200_0000 + 64'($urandom_range(0, 255) * 8);
      end
      e_r0 = 0; e_r1 = 0; e_wen = 0; e_ren = 0; e_rv0 = 0; e_rv1 = 0; e_addr = 0; e_wd = 0;
      if (c == grant_c + 1) begin
        hit = (t_addr == MTIME) || (t_addr == MTCMP);
        e_addr = t_addr; e_wd = t_wd; e_wen = hit && t_wen; e_ren = hit && !t_wen;
        exp_data = t_wen ? 64'd0 : (t_addr == MTIME) ? ref_mtime : (t_addr == MTCMP) ? ref_cmp : 64'd0;
        exp_err = !hit;
      end
      if (c == grant_c + 2) begin
        e_rv0 = (t_id == 0); e_rv1 = (t_id == 1);
      end
      if (c >= next_free && (v0 || v1)) begin
        win = (v0 && v1) ? ~m_last : v1;
        e_r0 = ~win; e_r1 = win; m_last = win;
        grant_c = c; next_free = c + 3; t_id = win;
        t_wen = win ? w1 : w0; t_addr = win ? a1 : a0; t_wd = win ? d1 : d0;
      end
      #1;
      checks++;
      if ({r0, r1} !== {e_r0, e_r1}) begin
        errors++; $display("FAIL rnd_ready c=%0d got %b%b exp %b%b", c, r0, r1, e_r0, e_r1);
      end
      checks++;
      if ({cwen, cren} !== {e_wen, e_ren} || caddr !== e_addr || cwd !== e_wd) begin
        errors++; $display("FAIL rnd_clint c=%0d got %b%b %h %h exp %b%b %h %h", c, cwen, cren, caddr, cwd, e_wen, e_ren, e_addr, e_wd);
      end
      checks++;
      if ({rv0, rv1} !== {e_rv0, e_rv1}) begin
        errors++; $display("FAIL rnd_rvalid c=%0d got %b%b exp %b%b", c, rv0, rv1, e_rv0, e_rv1);
      end
      if (e_rv0 || e_rv1) begin
        checks++;
        if ((e_rv0 ? rd0 : rd1) !== exp_data || (e_rv0 ? e0 : e1) !== exp_err) begin
          errors++; $display("FAIL rnd_resp c=%0d got %h %b exp %h %b", c, e_rv0 ? rd0 : rd1, e_rv0 ? e0 : e1, exp_data, exp_err);
        end
      end
      got0 = r0; got1 = r1;
      if (c == grant_c + 1 && t_wen && t_addr == MTIME) ref_mtime = t_wd;
      else ref_mtime = ref_mtime + 64'd1;
      if (c == grant_c + 1 && t_wen && t_addr == MTCMP) ref_cmp = t_wd;
    end
    drop_and_settle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_cmp();
    test_contention();
    test_decode_err();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
